// File: rtl/i2c_banked_ram_controller.sv
// Multi-bank data RAM for the I2C datapath. Each bank has its own write port,
// a registered read-first read port, and a sequential clear engine that fills
// the bank with CLEAR_VAL, with a busy/done handshake and an optional clear
// after reset.
`timescale 1ns/1ps
module i2c_banked_ram_controller #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned N_BANKS    = 2,
  parameter int unsigned CLEAR_VAL  = 32'h20,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_BANKS-1:0]          wr_en,
  input  logic [N_BANKS*ADDR_W-1:0]   wr_addr,
  input  logic [N_BANKS*DATA_W-1:0]   wr_data,
  input  logic [N_BANKS*ADDR_W-1:0]   rd_addr,
  output logic [N_BANKS*DATA_W-1:0]   rd_data,
  input  logic [N_BANKS-1:0]          clr_req,
  output logic [N_BANKS-1:0]          clr_busy,
  output logic [N_BANKS-1:0]          clr_done,
  output logic [N_BANKS-1:0]          wr_drop
);

  localparam int unsigned       DEPTH      = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] CLEAR_WORD = DATA_W'(CLEAR_VAL);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clrState_t;

  for (genvar gi = 0; gi < N_BANKS; gi++) begin : gBank
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wrAddr, rdAddr, cnt;
    logic [DATA_W-1:0] wrData, rdData;
    clrState_t         state;
    logic              initPending, busy, done, drop;
    logic              startReq;

    assign wrAddr   = wr_addr[gi*ADDR_W +: ADDR_W];
    assign rdAddr   = rd_addr[gi*ADDR_W +: ADDR_W];
    assign wrData   = wr_data[gi*DATA_W +: DATA_W];
    // The post-reset clear is just an extra request seen on the first edge.
    assign startReq = clr_req[gi] | initPending;

    // Storage write port: the clear engine owns the port while clearing,
    // so user writes in that window are simply not performed.
    always_ff @(posedge clk) begin
      if (state == CLEAR) begin
        mem[cnt] <= CLEAR_WORD;
      end else if (wr_en[gi]) begin
        mem[wrAddr] <= wrData;
      end
    end

    // Registered read port, read-first against a same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdData <= '0;
      end else begin
        rdData <= mem[rdAddr];
      end
    end

    // Clear sequencer: walks cnt over every address, restarts on a new
    // request, and flags user writes that collide with the sequence.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state       <= IDLE;
        cnt         <= '0;
        busy        <= 1'b0;
        done        <= 1'b0;
        drop        <= 1'b0;
        initPending <= INIT_CLEAR;
      end else begin
        initPending <= 1'b0;
        case (state)
          IDLE, DONE: begin
            done <= 1'b0;
            if (startReq) begin
              state <= CLEAR;
              cnt   <= '0;
              busy  <= 1'b1;
              drop  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
          CLEAR: begin
            // A collided write is reported even if a new request arrives.
            if (clr_req[gi]) drop <= 1'b0;
            if (wr_en[gi])   drop <= 1'b1;
            if (clr_req[gi]) begin
              cnt <= '0;
            end else if (cnt == LAST_ADDR) begin
              state <= DONE;
              cnt   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end

    assign rd_data[gi*DATA_W +: DATA_W] = rdData;
    assign clr_busy[gi] = busy;
    assign clr_done[gi] = done;
    assign wr_drop[gi]  = drop;
  end

endmodule
